entrada_pin: RTL

- Keypad PIN collector that sits directly upstream of the parking-gate controller and drives its 8-bit Pin input.
- Accepts decimal key presses only while a vehicle is present.
- Assembles two BCD digits into Pin = {digit1, digit2} and presents that value for PULSO cycles, then returns Pin to the idle value 8'h00.
- 8'h00 is reserved as "no PIN"; the controller treats any non-zero Pin as an entry attempt.

---
 rtl/entrada_pin.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/entrada_pin.sv
// Keypad PIN collector: gathers two BCD digits while a vehicle is present and
// presents {digit1, digit2} on Pin for PULSO cycles to the gate controller.
module entrada_pin #(
  parameter int unsigned TIMEOUT = 20,
  parameter int unsigned PULSO   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Vehiculo,
  input  logic       Tecla_valida,
  input  logic [3:0] Tecla,
  output logic [7:0] Pin,
  output logic       Pin_listo,
  output logic       Error,
  output logic [1:0] Digitos
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = (PULSO > 1) ? $clog2(PULSO) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(PULSO - 1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    DIGITO1 = 2'd1,
    DIGITO2 = 2'd2,
    ENTREGA = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    d1, d1_n;
  logic [7:0]    pin_n;
  logic          listo_n, error_n;
  logic [1:0]    digitos_n;

  logic es_digito, es_borrar, es_invalida;

  assign es_digito   = Tecla_valida && (Tecla <= 4'd9);
  assign es_borrar   = Tecla_valida && (Tecla == 4'hA);
  assign es_invalida = Tecla_valida && (Tecla > 4'hA);

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= ESPERA;
      timer     <= '0;
      cnt       <= '0;
      d1        <= '0;
      Pin       <= 8'h00;
      Pin_listo <= 1'b0;
      Error     <= 1'b0;
      Digitos   <= 2'd0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      cnt       <= cnt_n;
      d1        <= d1_n;
      Pin       <= pin_n;
      Pin_listo <= listo_n;
      Error     <= error_n;
      Digitos   <= digitos_n;
    end
  end

  // Next state and next output values; counters clear unless the state is held
  always_comb begin
    state_n   = state;
    timer_n   = '0;
    cnt_n     = '0;
    d1_n      = d1;
    pin_n     = 8'h00;
    listo_n   = 1'b0;
    error_n   = 1'b0;
    digitos_n = Digitos;

    case (state)
      ESPERA: begin
        digitos_n = 2'd0;
        if (Vehiculo) state_n = DIGITO1;
      end

      DIGITO1: begin
        if (!Vehiculo) begin
          state_n   = ESPERA;
          digitos_n = 2'd0;
        end else if (es_digito) begin
          d1_n      = Tecla;
          digitos_n = 2'd1;
          state_n   = DIGITO2;
        end else if (es_invalida) begin
          error_n = 1'b1;
        end
      end

      DIGITO2: begin
        if (!Vehiculo) begin
          state_n   = ESPERA;
          digitos_n = 2'd0;
        end else if (es_digito) begin
          if ({d1, Tecla} == 8'h00) begin
            error_n   = 1'b1;
            digitos_n = 2'd0;
            state_n   = DIGITO1;
          end else begin
            pin_n   = {d1, Tecla};
            listo_n = 1'b1;
            state_n = ENTREGA;
          end
        end else if (es_borrar) begin
          digitos_n = 2'd0;
          state_n   = DIGITO1;
        end else if (es_invalida) begin
          error_n = 1'b1;
          timer_n = (timer == TIMER_MAX) ? timer : timer + TW'(1);
        end else if (timer == TIMER_MAX) begin
          error_n   = 1'b1;
          digitos_n = 2'd0;
          state_n   = DIGITO1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      ENTREGA: begin
        if (cnt == CNT_MAX) begin
          digitos_n = 2'd0;
          state_n   = Vehiculo ? DIGITO1 : ESPERA;
        end else begin
          cnt_n   = cnt + CW'(1);
          pin_n   = Pin;
          listo_n = 1'b1;
        end
      end

      default: state_n = ESPERA;
    endcase
  end

endmodule
